// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - pipeline-side and memory-bus-side signals of the memory arbiter
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction fetch port (read-only)
    logic              iIF_req;
    logic [AW-1:0]     iIF_addr;
    logic              iFlush_IF;
    logic [DW-1:0]     oIF_rdata;
    logic              oIF_valid;
    logic              oStall_IF;

    // Data memory stage port (read/write)
    logic              iME_req;
    logic              iME_we;
    logic [DW/8-1:0]   iME_be;
    logic [AW-1:0]     iME_addr;
    logic [DW-1:0]     iME_wdata;
    logic [DW-1:0]     oME_rdata;
    logic              oME_valid;
    logic              oStall_ME;

    // External memory bus
    logic              oBus_req;
    logic              oBus_we;
    logic [DW/8-1:0]   oBus_be;
    logic [AW-1:0]     oBus_addr;
    logic [DW-1:0]     oBus_wdata;
    logic              iBus_gnt;
    logic              iBus_rvalid;
    logic [DW-1:0]     iBus_rdata;

    // Arbiter view
    modport master (
        input  iIF_req, iIF_addr, iFlush_IF,
        output oIF_rdata, oIF_valid, oStall_IF,
        input  iME_req, iME_we, iME_be, iME_addr, iME_wdata,
        output oME_rdata, oME_valid, oStall_ME,
        output oBus_req, oBus_we, oBus_be, oBus_addr, oBus_wdata,
        input  iBus_gnt, iBus_rvalid, iBus_rdata
    );

    // Environment view (pipeline stages and memory)
    modport slave (
        output iIF_req, iIF_addr, iFlush_IF,
        input  oIF_rdata, oIF_valid, oStall_IF,
        output iME_req, iME_we, iME_be, iME_addr, iME_wdata,
        input  oME_rdata, oME_valid, oStall_ME,
        input  oBus_req, oBus_we, oBus_be, oBus_addr, oBus_wdata,
        output iBus_gnt, iBus_rvalid, iBus_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-bus arbiter between instruction fetch and data memory stage
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          iClk,
    input  logic          nRst,
    mem_arbiter_if.master bus
);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_IF  = 3'd1,
        WAIT_IF = 3'd2,
        REQ_ME  = 3'd3,
        WAIT_ME = 3'd4
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [CW-1:0]   starveCnt;
    logic            flushed;
    logic [AW-1:0]   addrQ;
    logic            weQ;
    logic [BW-1:0]   beQ;
    logic [DW-1:0]   wdataQ;

    logic            ifReady;
    logic            starved;
    logic            pickMe;
    logic            pickIf;
    logic            busReq;
    logic            ifValid;
    logic            meValid;

    // A flushed IF request is not a real fetch, so it never competes in IDLE.
    assign ifReady = bus.iIF_req & ~bus.iFlush_IF;
    assign starved = (starveCnt == CW'(STARVE_MAX));
    assign pickMe  = (state == IDLE) & bus.iME_req & ~(ifReady & starved);
    assign pickIf  = (state == IDLE) & ifReady & ~pickMe;

    // State register
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, bus request and completion pulses
    always_comb begin
        stateNext = state;
        busReq    = 1'b0;
        ifValid   = 1'b0;
        meValid   = 1'b0;
        case (state)
            IDLE: begin
                if (pickMe) begin
                    stateNext = REQ_ME;
                end else if (pickIf) begin
                    stateNext = REQ_IF;
                end
            end
            REQ_IF: begin
                busReq = 1'b1;
                if (bus.iBus_gnt) begin
                    stateNext = WAIT_IF;
                end
            end
            WAIT_IF: begin
                if (bus.iBus_rvalid) begin
                    stateNext = IDLE;
                    // A flush arriving together with the response still discards it.
                    ifValid   = ~(flushed | bus.iFlush_IF);
                end
            end
            REQ_ME: begin
                busReq = 1'b1;
                if (bus.iBus_gnt) begin
                    stateNext = WAIT_ME;
                end
            end
            WAIT_ME: begin
                if (bus.iBus_rvalid) begin
                    stateNext = IDLE;
                    meValid   = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Starvation counter: counts ME wins over a waiting IF, cleared once IF is served or gone
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            starveCnt <= '0;
        end else if (pickIf) begin
            starveCnt <= '0;
        end else if (pickMe && bus.iIF_req) begin
            if (!starved) begin
                starveCnt <= starveCnt + CW'(1);
            end
        end else if ((state == IDLE) && !bus.iIF_req) begin
            starveCnt <= '0;
        end
    end

    // Flushed flag: remembers that the in-flight IF response must be dropped
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            flushed <= 1'b0;
        end else if (stateNext == IDLE) begin
            flushed <= 1'b0;
        end else if (((state == REQ_IF) || (state == WAIT_IF)) && bus.iFlush_IF) begin
            flushed <= 1'b1;
        end
    end

    // Request latch: captures the winner on the arbitration edge so the bus sees stable values
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            addrQ  <= '0;
            weQ    <= 1'b0;
            beQ    <= '0;
            wdataQ <= '0;
        end else if (pickMe) begin
            addrQ  <= bus.iME_addr;
            weQ    <= bus.iME_we;
            beQ    <= bus.iME_be;
            wdataQ <= bus.iME_wdata;
        end else if (pickIf) begin
            addrQ  <= bus.iIF_addr;
            weQ    <= 1'b0;
            beQ    <= '1;
            wdataQ <= '0;
        end
    end

    assign bus.oBus_req   = busReq;
    assign bus.oBus_we    = weQ;
    assign bus.oBus_be    = beQ;
    assign bus.oBus_addr  = addrQ;
    assign bus.oBus_wdata = wdataQ;

    assign bus.oIF_valid  = ifValid;
    assign bus.oIF_rdata  = bus.iBus_rdata;
    assign bus.oME_valid  = meValid;
    assign bus.oME_rdata  = bus.iBus_rdata;

    assign bus.oStall_IF  = bus.iIF_req & ~ifValid;
    assign bus.oStall_ME  = bus.iME_req & ~meValid;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory bus between instruction fetch (IF, read-only) and the data memory stage (ME, read/write).
- Issues one bus transaction at a time. Returns each response to the correct requester.
- Generates the oStall_IF / oStall_ME signals that the hazard unit consumes as its memory-unit-busy inputs.
- Sits between the pipeline's IF/ME stages and the external memory bus.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; byte-enable width is DW/8.
- STARVE_MAX, 4, number of consecutive ME grants while IF is waiting, after which IF is granted next.

Ports:
- iClk  in  1  clock.
- nRst  in  1  asynchronous active-low reset.
- iIF_req  in  1  IF read request; held until oIF_valid.
- iIF_addr  in  AW  IF address.
- iFlush_IF  in  1  branch flush; discard any in-flight IF transaction.
- oIF_rdata  out  DW  IF read data; valid with oIF_valid.
- oIF_valid  out  1  IF completion pulse.
- oStall_IF  out  1  IF stall.
- iME_req  in  1  ME request; held until oME_valid.
- iME_we  in  1  ME write enable.
- iME_be  in  DW/8  ME byte enables.
- iME_addr  in  AW  ME address.
- iME_wdata  in  DW  ME write data.
- oME_rdata  out  DW  ME read data.
- oME_valid  out  1  ME completion pulse.
- oStall_ME  out  1  ME stall.
- oBus_req  out  1  bus request.
- oBus_we  out  1  bus write.
- oBus_be  out  DW/8  bus byte enables.
- oBus_addr  out  AW  bus address.
- oBus_wdata  out  DW  bus write data.
- iBus_gnt  in  1  bus accepted the request this cycle.
- iBus_rvalid  in  1  response (read data or write ack).
- iBus_rdata  in  DW  response data.

Behaviour:
- Reset (nRst low, asynchronous):
  - State goes to IDLE; starvation counter, flushed flag and latched request registers clear.
  - All bus outputs are 0; oIF_valid and oME_valid are 0.
  - Reset asserted mid-transaction abandons it; a later rvalid arriving in IDLE is ignored.
- States: IDLE, REQ_IF, WAIT_IF, REQ_ME, WAIT_ME.
- Arbitration happens in IDLE only, one decision per cycle:
  - ME only -> REQ_ME.
  - IF only (and iFlush_IF low) -> REQ_IF.
  - Both requesting -> ME wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
  - iIF_req with iFlush_IF high in IDLE is not arbitrated that cycle.
- Latching: address, we, be and wdata are registered on the arbitration edge. Bus outputs are driven from these registers only and stay stable until granted.
- REQ_x:
  - oBus_req = 1 for the whole state.
  - The request is never retracted, including on flush.
  - iBus_gnt -> WAIT_x.
- WAIT_x:
  - oBus_req = 0.
  - iBus_rvalid -> IDLE.
  - In the same cycle oX_valid = 1 (combinational) and oX_rdata = iBus_rdata.
- Minimum latency: request seen at cycle 0, oBus_req at cycle 1 with gnt at cycle 1, rvalid and oX_valid at cycle 2.
- Writes: iBus_rvalid is the write ack. oME_valid pulses; oME_rdata is don't-care.
- Stall: oStall_X = iX_req & ~oX_valid.
- Flush:
  - iFlush_IF while in REQ_IF or WAIT_IF sets the flushed flag.
  - The transaction completes on the bus, but oIF_valid is suppressed on its rvalid.
  - The flag clears on return to IDLE.
  - Flush in any ME state has no effect.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each ME grant made while iIF_req is high.
  - Clears on an IF grant, or in any IDLE cycle with iIF_req low.
- No response without a matching request: iBus_rvalid in IDLE, REQ_x or during reset is ignored.

Test Plan:
- Reset mid-WAIT_ME then release; inject rvalid -> oME_valid stays 0, state is IDLE, all bus outputs are 0.
- IF read of 0x100 alone with zero-wait bus (gnt in cycle 1, rvalid in cycle 2 with rdata 0xDEADBEEF) -> oBus_addr=0x100 in cycle 1; oIF_valid and rdata=0xDEADBEEF in cycle 2; oStall_IF high in cycles 0-1 only.
- IF and ME request together; ME is a write to 0x200 with be=4'b0011 -> ME granted first with oBus_we=1 and be=0011; IF issued only after oME_valid.
- Continuous ME requests with IF held -> after 4 consecutive ME grants, the 5th grant goes to IF; starve_cnt then reads 0.
- IF read to 0x300 granted; assert iFlush_IF in WAIT_IF; then rvalid -> no oIF_valid; the next IF request to 0x400 issues afterward and returns normally.
- gnt held low 5 cycles in REQ_ME -> oBus_req and the address/data outputs are stable for all 5 cycles, and oStall_ME stays high throughout.
